// File: rtl/mc_ctrl_if.sv
// Control bundle between the mc_ctrl sequencer and the MIPS-lite datapath/memory.
// The master side is the controller; the slave side is the datapath that obeys it.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       pc_en;
  logic       ir_en;
  logic       reg_we;
  logic       alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] ext_op;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] pc_src;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, mem_we, pc_en, ir_en, reg_we, alu_src_b, alu_op, ext_op,
           reg_dst, mem_to_reg, pc_src, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, mem_we, pc_en, ir_en, reg_we, alu_src_b, alu_op, ext_op,
           reg_dst, mem_to_reg, pc_src, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-lite core: fetch/decode/execute/memory/write-back
// sequencing with a request/ready memory handshake.
module mc_ctrl (
   input  logic      clk,
   input  logic      reset,
   mc_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,  StDecode = 4'd1,  StMemAdr = 4'd2,  StMemRd  = 4'd3,
      StMemWb  = 4'd4,  StMemWr  = 4'd5,  StExec   = 4'd6,  StAluWb  = 4'd7,
      StExecI  = 4'd8,  StAluWbI = 4'd9,  StBranch = 4'd10, StJump   = 4'd11,
      StJal    = 4'd12, StJr     = 4'd13
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpLui   = 6'b001111;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpJal   = 6'b000011;
   localparam logic [5:0] FnAddu  = 6'b100001;
   localparam logic [5:0] FnSubu  = 6'b100011;
   localparam logic [5:0] FnJr    = 6'b001000;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluOr  = 3'b010;

   state_e state_q, state_d;
   // Instruction flavour captured in DECODE so EXEC/EXECI never look at the IR fields.
   logic   sub_q, sub_d, lui_q, lui_d;

   logic       mem_req, mem_we, pc_en, ir_en, reg_we, alu_src_b;
   logic [2:0] alu_op;
   logic [1:0] ext_op, reg_dst, mem_to_reg, pc_src;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StFetch;
         sub_q   <= 1'b0;
         lui_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sub_q   <= sub_d;
         lui_q   <= lui_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sub_d      = sub_q;
      lui_d      = lui_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      pc_en      = 1'b0;
      ir_en      = 1'b0;
      reg_we     = 1'b0;
      alu_src_b  = 1'b0;
      alu_op     = AluAdd;
      ext_op     = 2'b00;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      pc_src     = 2'b00;

      case (state_q)
         StFetch: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               ir_en   = 1'b1;
               pc_en   = 1'b1;
               state_d = StDecode;
            end
         end
         StDecode: begin
            sub_d   = (bus.funct == FnSubu);
            lui_d   = (bus.opcode == OpLui);
            state_d = StFetch;
            case (bus.opcode)
               OpRtype: begin
                  case (bus.funct)
                     FnAddu, FnSubu: state_d = StExec;
                     FnJr:           state_d = StJr;
                     default:        state_d = StFetch;
                  endcase
               end
               OpLw, OpSw:   state_d = StMemAdr;
               OpOri, OpLui: state_d = StExecI;
               OpBeq:        state_d = StBranch;
               OpJ:          state_d = StJump;
               OpJal:        state_d = StJal;
               default:      state_d = StFetch;
            endcase
         end
         StMemAdr: begin
            alu_src_b = 1'b1;
            ext_op    = 2'b01;
            if (bus.opcode == OpLw)      state_d = StMemRd;
            else if (bus.opcode == OpSw) state_d = StMemWr;
            else                         state_d = StFetch;
         end
         StMemRd: begin
            mem_req = 1'b1;
            if (bus.mem_ready) state_d = StMemWb;
         end
         StMemWb: begin
            reg_we     = 1'b1;
            mem_to_reg = 2'b01;
            state_d    = StFetch;
         end
         StMemWr: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (bus.mem_ready) state_d = StFetch;
         end
         StExec: begin
            alu_op  = sub_q ? AluSub : AluAdd;
            state_d = StAluWb;
         end
         StAluWb: begin
            reg_we  = 1'b1;
            reg_dst = 2'b01;
            state_d = StFetch;
         end
         StExecI: begin
            alu_src_b = 1'b1;
            ext_op    = lui_q ? 2'b10 : 2'b00;
            alu_op    = lui_q ? AluAdd : AluOr;
            state_d   = StAluWbI;
         end
         StAluWbI: begin
            reg_we  = 1'b1;
            state_d = StFetch;
         end
         StBranch: begin
            alu_op  = AluSub;
            pc_src  = 2'b01;
            pc_en   = bus.zero;
            state_d = StFetch;
         end
         StJump: begin
            pc_en   = 1'b1;
            pc_src  = 2'b10;
            state_d = StFetch;
         end
         StJal: begin
            pc_en      = 1'b1;
            pc_src     = 2'b10;
            reg_we     = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            state_d    = StFetch;
         end
         StJr: begin
            pc_en   = 1'b1;
            pc_src  = 2'b11;
            state_d = StFetch;
         end
         default: state_d = StFetch;
      endcase

      // Reset overrides FETCH's request so a held-off memory sees nothing.
      if (!reset) begin
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         pc_en      = 1'b0;
         ir_en      = 1'b0;
         reg_we     = 1'b0;
         alu_src_b  = 1'b0;
         alu_op     = AluAdd;
         ext_op     = 2'b00;
         reg_dst    = 2'b00;
         mem_to_reg = 2'b00;
         pc_src     = 2'b00;
      end
   end

   assign bus.mem_req    = mem_req;
   assign bus.mem_we     = mem_we;
   assign bus.pc_en      = pc_en;
   assign bus.ir_en      = ir_en;
   assign bus.reg_we     = reg_we;
   assign bus.alu_src_b  = alu_src_b;
   assign bus.alu_op     = alu_op;
   assign bus.ext_op     = ext_op;
   assign bus.reg_dst    = reg_dst;
   assign bus.mem_to_reg = mem_to_reg;
   assign bus.pc_src     = pc_src;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction vector table plus hand-written
// sequences for reset, memory wait states and reset during a pending write.
module tb_mc_ctrl;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   mc_ctrl_if bus ();

   mc_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic [3:0]  key;
      int          lat;
      logic [16:0] exp;
   } vec_t;

   vec_t vt[17];

   // {mem_req, mem_we, pc_en, ir_en, reg_we, alu_src_b, alu_op, ext_op, reg_dst, mem_to_reg, pc_src}
   function automatic logic [16:0] ov(logic rq, logic we, logic pe, logic ie, logic rw,
                                      logic sb, logic [2:0] ao, logic [1:0] eo,
                                      logic [1:0] rd, logic [1:0] mr, logic [1:0] ps);
      return {rq, we, pe, ie, rw, sb, ao, eo, rd, mr, ps};
   endfunction

   function automatic logic [16:0] outs();
      return {bus.mem_req, bus.mem_we, bus.pc_en, bus.ir_en, bus.reg_we, bus.alu_src_b,
              bus.alu_op, bus.ext_op, bus.reg_dst, bus.mem_to_reg, bus.pc_src};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Entered at a negedge with the DUT in FETCH; leaves at the negedge it is back in FETCH.
   task automatic run_instr(input vec_t v);
      int  cyc;
      bit  seen;
      cyc  = 0;
      seen = 0;
      bus.opcode = v.op;
      bus.funct  = v.fn;
      bus.zero   = v.z;
      for (int i = 0; i < 20; i++) begin
         if (bus.state == v.key && !seen) begin
            chk({v.name, " outputs"}, 32'(outs()), 32'(v.exp));
            seen = 1;
         end
         cyc++;
         @(negedge clk);
         if (bus.state == 4'd0) break;
      end
      chk({v.name, " latency"}, 32'(cyc), 32'(v.lat));
      chk({v.name, " key state seen"}, 32'(seen), 32'd1);
   endtask

   initial begin
      logic [3:0] lw_seq [9];
      logic       lw_rdy [9];

      vt[0]  = '{"addu aluwb", 6'h00, 6'b100001, 1'b0, 4'd7,  4, ov(0,0,0,0,1,0,3'd0,2'd0,2'd1,2'd0,2'd0)};
      vt[1]  = '{"addu exec",  6'h00, 6'b100001, 1'b0, 4'd6,  4, ov(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,2'd0)};
      vt[2]  = '{"subu exec",  6'h00, 6'b100011, 1'b0, 4'd6,  4, ov(0,0,0,0,0,0,3'd1,2'd0,2'd0,2'd0,2'd0)};
      vt[3]  = '{"subu aluwb", 6'h00, 6'b100011, 1'b0, 4'd7,  4, ov(0,0,0,0,1,0,3'd0,2'd0,2'd1,2'd0,2'd0)};
      vt[4]  = '{"lw memadr",  6'b100011, 6'h00, 1'b0, 4'd2,  5, ov(0,0,0,0,0,1,3'd0,2'd1,2'd0,2'd0,2'd0)};
      vt[5]  = '{"lw memwb",   6'b100011, 6'h00, 1'b0, 4'd4,  5, ov(0,0,0,0,1,0,3'd0,2'd0,2'd0,2'd1,2'd0)};
      vt[6]  = '{"sw memwr",   6'b101011, 6'h00, 1'b0, 4'd5,  4, ov(1,1,0,0,0,0,3'd0,2'd0,2'd0,2'd0,2'd0)};
      vt[7]  = '{"ori execi",  6'b001101, 6'h00, 1'b0, 4'd8,  4, ov(0,0,0,0,0,1,3'd2,2'd0,2'd0,2'd0,2'd0)};
      vt[8]  = '{"lui execi",  6'b001111, 6'h00, 1'b0, 4'd8,  4, ov(0,0,0,0,0,1,3'd0,2'd2,2'd0,2'd0,2'd0)};
      vt[9]  = '{"lui aluwbi", 6'b001111, 6'h00, 1'b0, 4'd9,  4, ov(0,0,0,0,1,0,3'd0,2'd0,2'd0,2'd0,2'd0)};
      vt[10] = '{"beq taken",  6'b000100, 6'h00, 1'b1, 4'd10, 3, ov(0,0,1,0,0,0,3'd1,2'd0,2'd0,2'd0,2'd1)};
      vt[11] = '{"beq not",    6'b000100, 6'h00, 1'b0, 4'd10, 3, ov(0,0,0,0,0,0,3'd1,2'd0,2'd0,2'd0,2'd1)};
      vt[12] = '{"j",          6'b000010, 6'h00, 1'b0, 4'd11, 3, ov(0,0,1,0,0,0,3'd0,2'd0,2'd0,2'd0,2'd2)};
      vt[13] = '{"jal",        6'b000011, 6'h00, 1'b0, 4'd12, 3, ov(0,0,1,0,1,0,3'd0,2'd0,2'd2,2'd2,2'd2)};
      vt[14] = '{"jr",         6'h00, 6'b001000, 1'b0, 4'd13, 3, ov(0,0,1,0,0,0,3'd0,2'd0,2'd0,2'd0,2'd3)};
      vt[15] = '{"sll nop",    6'h00, 6'h00,     1'b0, 4'd1,  2, ov(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,2'd0)};
      vt[16] = '{"op 3f nop",  6'h3f, 6'h21,     1'b1, 4'd1,  2, ov(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,2'd0)};

      lw_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
      lw_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      // Reset held low for two cycles with memory ready.
      reset         = 1'b0;
      bus.opcode    = 6'h00;
      bus.funct     = 6'h00;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset outputs", 32'(outs()), 32'd0);
      chk("reset state", 32'(bus.state), 32'd0);
      reset = 1'b1;
      #1;
      chk("post-reset fetch enables", 32'({bus.mem_req, bus.pc_en, bus.ir_en}), 32'b111);
      @(negedge clk);
      chk("post-reset decode", 32'(bus.state), 32'd1);
      @(negedge clk);
      chk("post-reset nop back to fetch", 32'(bus.state), 32'd0);

      foreach (vt[i]) run_instr(vt[i]);

      // lw with three wait cycles in MEMRD.
      bus.opcode = 6'b100011;
      bus.funct  = 6'h00;
      for (int i = 0; i < 9; i++) begin
         bus.mem_ready = lw_rdy[i];
         #1;
         chk($sformatf("lw wait state[%0d]", i), 32'(bus.state), 32'(lw_seq[i]));
         if (lw_seq[i] == 4'd3) chk($sformatf("lw wait mem_req[%0d]", i), 32'(bus.mem_req), 32'd1);
         if (lw_seq[i] == 4'd4)
            chk("lw wait memwb", 32'({bus.reg_we, bus.mem_to_reg}), 32'b101);
         if (i < 8) @(negedge clk);
      end

      // sw: one fetch wait, then reset mid-write while memory is stalled.
      bus.opcode    = 6'b101011;
      bus.mem_ready = 1'b0;
      #1;
      chk("fetch stall enables", 32'({bus.mem_req, bus.pc_en, bus.ir_en}), 32'b100);
      @(negedge clk);
      chk("fetch stall holds", 32'(bus.state), 32'd0);
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("sw memadr", 32'(bus.state), 32'd2);
      @(negedge clk);
      @(negedge clk);
      chk("sw stalled state", 32'(bus.state), 32'd5);
      chk("sw stalled mem_we", 32'({bus.mem_req, bus.mem_we}), 32'b11);
      #2 reset = 1'b0;
      #1;
      chk("sw reset mem_we", 32'(bus.mem_we), 32'd0);
      chk("sw reset outputs", 32'(outs()), 32'd0);
      chk("sw reset state", 32'(bus.state), 32'd0);
      @(negedge clk);
      reset         = 1'b1;
      bus.mem_ready = 1'b1;
      run_instr(vt[16]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the MIPS-lite `mips` core. It sequences the shared datapath (PC, IR, register file, ALU, unified memory) through fetch, decode, execute, memory and write-back states, one instruction at a time. It also handles memory wait states through a request/ready handshake. It replaces the single-cycle decoder and sits between the IR opcode/funct fields and all datapath enables and muxes.

## Interface
Parameters:
- none; encodings below are fixed.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access in progress
- mem_we  out  1  data write strobe
- pc_en  out  1  PC load
- ir_en  out  1  IR load
- reg_we  out  1  register-file write
- alu_src_b  out  1  0 = B register, 1 = extended immediate
- alu_op  out  3  000 ADD, 001 SUB, 010 OR
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 memory data register, 10 current PC
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs value
- state  out  4  current state, for debug

## Operation
- Supported instructions:
  - R-type (opcode 000000) with funct addu 100001, subu 100011, jr 001000.
  - lw 100011, sw 101011, beq 000100, ori 001101, lui 001111, j 000010, jal 000011.
  - Any other opcode, or R-type with any other funct (including sll/nop), is a no-op.
- State encoding and behaviour. Any output not listed for a state is 0.
- FETCH 0: mem_req=1. When mem_ready=1: ir_en=1, pc_en=1, pc_src=00, then go to DECODE. Otherwise hold in FETCH.
- DECODE 1: no outputs. Next state by instruction:
  - lw, sw → MEMADR
  - addu, subu → EXEC
  - ori, lui → EXECI
  - beq → BRANCH
  - j → JUMP
  - jal → JAL
  - jr → JR
  - otherwise → FETCH
- MEMADR 2: alu_src_b=1, ext_op=01, alu_op=ADD. Next: lw → MEMRD, sw → MEMWR.
- MEMRD 3: mem_req=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB 4: reg_we=1, reg_dst=00, mem_to_reg=01, then go to FETCH.
- MEMWR 5: mem_req=1, mem_we=1. Hold until mem_ready=1, then go to FETCH.
- EXEC 6: alu_src_b=0, alu_op=ADD (addu) or SUB (subu), then go to ALUWB.
- ALUWB 7: reg_we=1, reg_dst=01, mem_to_reg=00, then go to FETCH.
- EXECI 8: alu_src_b=1, then go to ALUWBI.
  - ori: ext_op=00, alu_op=OR.
  - lui: ext_op=10, alu_op=ADD.
- ALUWBI 9: reg_we=1, reg_dst=00, mem_to_reg=00, then go to FETCH.
- BRANCH 10: alu_src_b=0, alu_op=SUB, pc_src=01, pc_en=zero (Mealy), then go to FETCH.
- JUMP 11: pc_en=1, pc_src=10, then go to FETCH.
- JAL 12: pc_en=1, pc_src=10, reg_we=1, reg_dst=10, mem_to_reg=10, then go to FETCH. The PC written to $31 is the pre-jump PC, which already equals jal address + 4.
- JR 13: pc_en=1, pc_src=11, then go to FETCH.
- Codes 14 and 15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.
- opcode and funct are sampled only in DECODE and MEMADR; the IR is stable there.

## Timing
- While reset=0: state=FETCH and every output is forced to 0, including mem_req.
- When reset rises: FETCH begins on the next clock.
- Outputs are decoded from the state register, except that FETCH pc_en/ir_en and BRANCH pc_en are combinationally qualified by mem_ready and zero respectively.
- Latency in clock cycles, with zero memory wait:
  - lw 5
  - sw, addu, subu, ori, lui 4
  - beq, j, jal, jr 3
  - no-op 2
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. mem_ready outside those states is ignored.
- mem_we stays asserted for the entire MEMWR wait. The memory must write exactly once, on the mem_ready cycle.
- Asynchronous reset mid-instruction abandons the instruction with no further enables; a pending memory write is dropped.

## Test plan
- Reset held low for 2 cycles with mem_ready=1 → all outputs 0 and state=0. First rising edge after release: pc_en=1, ir_en=1.
- addu (opcode 0, funct 100001), mem_ready=1 → state sequence 0,1,6,7,0. reg_we=1 only in state 7, with reg_dst=01.
- lw with mem_ready low for 3 cycles in MEMRD → sequence 0,1,2,3,3,3,3,4,0. reg_we=1 with mem_to_reg=01 in state 4.
- beq with zero=1, then beq with zero=0 → pc_en=1 with pc_src=01 in state 10 for the first, pc_en=0 for the second; both return to 0.
- jal → state 12 asserts pc_en, reg_we, reg_dst=10, mem_to_reg=10, pc_src=10 in the same cycle. jr returns via state 13 with pc_src=11.
- sw with mem_ready=0, reset pulsed low in MEMWR → mem_we drops to 0 immediately, state=0. opcode 111111 → sequence 0,1,0 with no enables after FETCH.
